mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage in the scmips core.
- Consumes the execute stage's Result (effective address or ALU value), the instruction, and Rdata2 (store data).
- Performs loads and stores over a request/acknowledge data-memory bus, and asserts Stall so the PC register upstream holds while an access is outstanding.
- Outputs the write-back value: loaded data or the passed-through Result.

---
 rtl/mem_access.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on a req/ack bus and stalls the PC until the access completes.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        InsValid,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Stall,
    output logic [31:0] WbData,
    output logic        BusErr,
    output logic        AdrErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemAck
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   load_data_q, load_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          bus_err_q, bus_err_d;
    logic          adr_err_q, adr_err_d;

    logic          dec_mem, dec_store, dec_sign, misaligned, timeout_hit;
    logic [1:0]    dec_size;
    logic [3:0]    dec_be;
    logic [31:0]   dec_wdata, ld_ext;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          unused_ins_bits;

    assign unused_ins_bits = ^Ins[25:0];

    // Opcode decode plus lane-placed byte enables and replicated store data
    always_comb begin
        dec_mem   = 1'b1;
        dec_store = 1'b0;
        dec_sign  = 1'b0;
        dec_size  = SZ_W;
        case (Ins[31:26])
            6'h20:   begin dec_size = SZ_B; dec_sign = 1'b1; end
            6'h21:   begin dec_size = SZ_H; dec_sign = 1'b1; end
            6'h23:   dec_size = SZ_W;
            6'h24:   dec_size = SZ_B;
            6'h25:   dec_size = SZ_H;
            6'h28:   begin dec_size = SZ_B; dec_store = 1'b1; end
            6'h29:   begin dec_size = SZ_H; dec_store = 1'b1; end
            6'h2B:   begin dec_size = SZ_W; dec_store = 1'b1; end
            default: dec_mem = 1'b0;
        endcase

        case (dec_size)
            SZ_B: begin
                dec_be    = 4'b0001 << Result[1:0];
                dec_wdata = {4{Rdata2[7:0]}};
            end
            SZ_H: begin
                dec_be    = Result[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{Rdata2[15:0]}};
            end
            default: begin
                dec_be    = 4'b1111;
                dec_wdata = Rdata2;
            end
        endcase

`ifdef MEM_ALIGN_CHECK_EN
        misaligned = ((dec_size == SZ_H) && Result[0]) ||
                     ((dec_size == SZ_W) && (Result[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Lane selection and extension of the returned word, driven by the latched access
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = MemRdata[7:0];
            2'd1:    ld_byte = MemRdata[15:8];
            2'd2:    ld_byte = MemRdata[23:16];
            default: ld_byte = MemRdata[31:24];
        endcase
        ld_half = addr_q[1] ? MemRdata[31:16] : MemRdata[15:0];
        case (size_q)
            SZ_B:    ld_ext = sign_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            SZ_H:    ld_ext = sign_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            default: ld_ext = MemRdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        sign_d      = sign_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        bus_err_d   = 1'b0;
        adr_err_d   = 1'b0;
        Stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (InsValid && dec_mem) begin
                    Stall   = 1'b1;
                    size_d  = dec_size;
                    sign_d  = dec_sign;
                    we_d    = dec_store;
                    addr_d  = Result;
                    be_d    = dec_be;
                    wdata_d = dec_wdata;
                    if (misaligned) begin
                        state_d     = DONE;
                        adr_err_d   = 1'b1;
                        load_data_d = 32'd0;
                    end else begin
                        state_d   = REQ;
                        cnt_d     = '0;
                        mem_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                // An ack arriving in the timeout cycle still completes the access normally
                if (MemAck) begin
                    state_d = DONE;
                    if (!we_q) begin
                        load_data_d = ld_ext;
                    end
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    load_data_d = 32'd0;
                    bus_err_d   = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            size_q      <= SZ_B;
            sign_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            adr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            bus_err_q   <= bus_err_d;
            adr_err_q   <= adr_err_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = we_q;
    assign MemAddr  = {addr_q[31:2], 2'b00};
    assign MemBe    = be_q;
    assign MemWdata = wdata_q;
    assign BusErr   = bus_err_q;
    assign AdrErr   = adr_err_q;
    assign WbData   = ((state_q == DONE) && !we_q) ? load_data_q : Result;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, reset corner case and randomized traffic
// checked against a transaction-level reference model.
module tb_mem_access;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        InsValid;
    logic [31:0] Ins, Result, Rdata2, MemRdata;
    logic        MemAck;
    logic        Stall, BusErr, AdrErr, MemReq, MemWe;
    logic [31:0] WbData, MemAddr, MemWdata;
    logic [3:0]  MemBe;

    int total = 0;
    int bad   = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins), .Result(Result),
        .Rdata2(Rdata2), .Stall(Stall), .WbData(WbData), .BusErr(BusErr), .AdrErr(AdrErr),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
        .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata2;
        logic [31:0] rdata;
        int          ack_at;
        bit          exp_mem;
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
        bit          exp_bus_err;
        bit          exp_adr_err;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_mem_op(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic bit is_store_op(input logic [5:0] op);
        return op inside {6'h28, 6'h29, 6'h2B};
    endfunction

    function automatic int op_size(input logic [5:0] op);
        if (op inside {6'h20, 6'h24, 6'h28}) return 1;
        if (op inside {6'h21, 6'h25, 6'h29}) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [5:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        return (addr % op_size(op)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Transaction-level model: everything derived from access size and byte offset arithmetic
    function automatic vec_t model(input logic [5:0] op, input logic [31:0] addr,
                                   input logic [31:0] rdata2, input logic [31:0] rdata,
                                   input int ack_at);
        vec_t        v;
        int          sz, off;
        logic [31:0] base, mask, val;
        v.op = op; v.addr = addr; v.rdata2 = rdata2; v.rdata = rdata; v.ack_at = ack_at;
        sz   = op_size(op);
        base = addr - (addr % sz);
        off  = int'(base % 4);
        v.exp_mem  = is_mem_op(op);
        v.exp_we   = is_store_op(op);
        v.exp_addr = addr & ~32'h3;
        v.exp_be   = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = rdata2[8*(i % sz) +: 8];
        v.exp_adr_err = v.exp_mem && model_misaligned(op, addr);
        v.exp_bus_err = v.exp_mem && !v.exp_adr_err && (ack_at > int'(TO));
        if (!v.exp_mem || v.exp_we) begin
            v.exp_wb = addr;
        end else if (v.exp_adr_err || v.exp_bus_err) begin
            v.exp_wb = 32'd0;
        end else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
            val  = (rdata >> (8*off)) & mask;
            if ((op inside {6'h20, 6'h21}) && val[8*sz-1]) val = val | ~mask;
            v.exp_wb = val;
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata2,
                                input logic [31:0] rdata, input int ack_at, input bit mem, input bit we,
                                input logic [31:0] eaddr, input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] wb, input bit berr, input bit aerr);
        vec_t v;
        v.op = op; v.addr = addr; v.rdata2 = rdata2; v.rdata = rdata; v.ack_at = ack_at;
        v.exp_mem = mem; v.exp_we = we; v.exp_addr = eaddr; v.exp_be = be; v.exp_wdata = wdata;
        v.exp_wb = wb; v.exp_bus_err = berr; v.exp_adr_err = aerr;
        return v;
    endfunction

    // Drives one instruction through issue, bus phase and write-back, checking each cycle
    task automatic apply_stimulus(input vec_t v);
        @(negedge CLK);
        InsValid = 1'b1;
        Ins      = {v.op, 26'($urandom)};
        Result   = v.addr;
        Rdata2   = v.rdata2;
        MemAck   = 1'b0;
        MemRdata = $urandom;
        #1;
        if (!v.exp_mem) begin
            check_output("nonmem_stall_req", {30'd0, Stall, MemReq}, 32'd0);
            check_output("nonmem_wb", WbData, v.addr);
            @(negedge CLK);
            #1;
            check_output("nonmem_next_stall_req", {30'd0, Stall, MemReq}, 32'd0);
            InsValid = 1'b0;
            return;
        end
        check_output("issue_stall", {31'd0, Stall}, 32'd1);
        check_output("issue_req", {31'd0, MemReq}, 32'd0);
        if (!v.exp_adr_err) begin
            for (int c = 1; c <= int'(TO); c++) begin
                @(negedge CLK);
                if (c == v.ack_at) begin
                    MemAck   = 1'b1;
                    MemRdata = v.rdata;
                end else begin
                    MemAck   = 1'b0;
                    MemRdata = $urandom;
                end
                #1;
                check_output("req_stall_req", {30'd0, Stall, MemReq}, 32'd3);
                check_output("req_we_be", {27'd0, MemWe, MemBe}, {27'd0, v.exp_we, v.exp_be});
                check_output("req_addr", MemAddr, v.exp_addr);
                if (v.exp_we) check_output("req_wdata", MemWdata, v.exp_wdata);
                if (c == v.ack_at) break;
            end
        end
        @(negedge CLK);
        MemAck = 1'b0;
        #1;
        check_output("done_stall_req", {30'd0, Stall, MemReq}, 32'd0);
        check_output("done_wb", WbData, v.exp_wb);
        check_output("done_buserr", {31'd0, BusErr}, {31'd0, v.exp_bus_err});
        check_output("done_adrerr", {31'd0, AdrErr}, {31'd0, v.exp_adr_err});
        @(negedge CLK);
        InsValid = 1'b0;
        MemAck   = 1'b1;
        #1;
        check_output("idle_after", {28'd0, Stall, MemReq, BusErr, AdrErr}, 32'd0);
    endtask

    vec_t       tbl[$];
    logic [5:0] ops[13] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                            6'h00, 6'h08, 6'h0D, 6'h22, 6'h2A};

    initial begin
        RST = 1'b1; InsValid = 1'b0; Ins = 32'd0; Result = 32'h0000_1234;
        Rdata2 = 32'd0; MemAck = 1'b0; MemRdata = 32'd0;
        #12;
        check_output("reset_ctrl", {28'd0, Stall, MemReq, BusErr, AdrErr}, 32'd0);
        check_output("reset_we_be", {27'd0, MemWe, MemBe}, 32'd0);
        check_output("reset_addr", MemAddr, 32'd0);
        check_output("reset_wb", WbData, 32'h0000_1234);
        @(negedge CLK);
        RST = 1'b0;

        tbl.push_back(mk(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1, 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(6'h20, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 0));
        tbl.push_back(mk(6'h24, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 0, 0));
        tbl.push_back(mk(6'h29, 32'h22, 32'h1234ABCD, 32'h0, 3, 1, 1, 32'h20, 4'b1100, 32'hABCDABCD, 32'h22, 0, 0));
        tbl.push_back(mk(6'h00, 32'h55, 32'h0, 32'h0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h55, 0, 0));
        tbl.push_back(mk(6'h23, 32'h200, 32'h0, 32'h0, 17, 1, 0, 32'h200, 4'hF, 32'h0, 32'h0, 1, 0));
        tbl.push_back(mk(6'h23, 32'h204, 32'h0, 32'h13572468, 16, 1, 0, 32'h204, 4'hF, 32'h0, 32'h13572468, 0, 0));
        tbl.push_back(mk(6'h21, 32'h10A, 32'h0, 32'h80017FFE, 1, 1, 0, 32'h108, 4'b1100, 32'h0, 32'hFFFF8001, 0, 0));
        tbl.push_back(mk(6'h25, 32'h108, 32'h0, 32'h8001F00D, 1, 1, 0, 32'h108, 4'b0011, 32'h0, 32'h0000F00D, 0, 0));
        tbl.push_back(mk(6'h28, 32'h31, 32'hAABBCCDD, 32'h0, 2, 1, 1, 32'h30, 4'b0010, 32'hDDDDDDDD, 32'h31, 0, 0));
        tbl.push_back(mk(6'h2B, 32'h40, 32'hCAFEF00D, 32'h0, 1, 1, 1, 32'h40, 4'hF, 32'hCAFEF00D, 32'h40, 0, 0));
        tbl.push_back(mk(6'h20, 32'h101, 32'h0, 32'h00007F00, 4, 1, 0, 32'h100, 4'b0010, 32'h0, 32'h0000007F, 0, 0));
`ifdef MEM_ALIGN_CHECK_EN
        tbl.push_back(mk(6'h23, 32'h102, 32'h0, 32'h11223344, 1, 1, 0, 32'h100, 4'hF, 32'h0, 32'h0, 0, 1));
        tbl.push_back(mk(6'h21, 32'h105, 32'h0, 32'hAAAA8765, 1, 1, 0, 32'h104, 4'b0011, 32'h0, 32'h0, 0, 1));
`else
        tbl.push_back(mk(6'h23, 32'h102, 32'h0, 32'h11223344, 1, 1, 0, 32'h100, 4'hF, 32'h0, 32'h11223344, 0, 0));
        tbl.push_back(mk(6'h21, 32'h105, 32'h0, 32'hAAAA8765, 1, 1, 0, 32'h104, 4'b0011, 32'h0, 32'hFFFF8765, 0, 0));
`endif
        for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);

        // Asynchronous reset in the second REQ cycle abandons the access immediately
        @(negedge CLK);
        InsValid = 1'b1; Ins = {6'h23, 26'd0}; Result = 32'h300; MemAck = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check_output("pre_rst_req", {31'd0, MemReq}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check_output("rst_req", {31'd0, MemReq}, 32'd0);
        check_output("rst_we_be", {27'd0, MemWe, MemBe}, 32'd0);
        check_output("rst_addr", MemAddr, 32'd0);
        check_output("rst_stall", {31'd0, Stall}, 32'd1);
        check_output("rst_wb", WbData, 32'h300);
        InsValid = 1'b0;
        #1;
        check_output("rst_stall_idle", {31'd0, Stall}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [5:0]  op;
            logic [31:0] addr;
            op   = ops[$urandom_range(0, 12)];
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'h3;
            apply_stimulus(model(op, addr, $urandom, $urandom, int'($urandom_range(1, TO + 2))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
